// File: rtl/axi_lite_arbiter_2x1.sv
// Two-master, one-slave AXI-lite arbiter: one transaction in flight at a time,
// round-robin between the fetch master (m0) and the data master (m1).
module axi_lite_arbiter_2x1 #(
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_AXI_ADDR_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              rstn,
  // requester 0 (instruction fetch)
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     m0_araddr,
  input  logic [2:0]                        m0_arprot,
  input  logic                              m0_arvalid,
  output logic                              m0_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     m0_rdata,
  output logic [1:0]                        m0_rresp,
  output logic                              m0_rvalid,
  input  logic                              m0_rready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     m0_awaddr,
  input  logic [2:0]                        m0_awprot,
  input  logic                              m0_awvalid,
  output logic                              m0_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     m0_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   m0_wstrb,
  input  logic                              m0_wvalid,
  output logic                              m0_wready,
  output logic [1:0]                        m0_bresp,
  output logic                              m0_bvalid,
  input  logic                              m0_bready,
  // requester 1 (data)
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     m1_araddr,
  input  logic [2:0]                        m1_arprot,
  input  logic                              m1_arvalid,
  output logic                              m1_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     m1_rdata,
  output logic [1:0]                        m1_rresp,
  output logic                              m1_rvalid,
  input  logic                              m1_rready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     m1_awaddr,
  input  logic [2:0]                        m1_awprot,
  input  logic                              m1_awvalid,
  output logic                              m1_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     m1_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   m1_wstrb,
  input  logic                              m1_wvalid,
  output logic                              m1_wready,
  output logic [1:0]                        m1_bresp,
  output logic                              m1_bvalid,
  input  logic                              m1_bready,
  // shared RAM slave
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     s_araddr,
  output logic [2:0]                        s_arprot,
  output logic                              s_arvalid,
  input  logic                              s_arready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_rdata,
  input  logic [1:0]                        s_rresp,
  input  logic                              s_rvalid,
  output logic                              s_rready,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     s_awaddr,
  output logic [2:0]                        s_awprot,
  output logic                              s_awvalid,
  input  logic                              s_awready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_wdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_wstrb,
  output logic                              s_wvalid,
  input  logic                              s_wready,
  input  logic [1:0]                        s_bresp,
  input  logic                              s_bvalid,
  output logic                              s_bready,
  output logic                              debug_grant,
  output logic [2:0]                        debug_state
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_ADDR = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

  logic [2:0] state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic rd_req0, rd_req1, req0, req1, sel;
  logic in_rd_addr, in_rd_data, in_wr_addr, in_wr_resp;
  logic aw_hs, w_hs;

  // Signals of whichever master currently holds the grant
  logic g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;

  assign rd_req0 = m0_arvalid;
  assign rd_req1 = m1_arvalid;
  assign req0    = m0_arvalid | (m0_awvalid & m0_wvalid);
  assign req1    = m1_arvalid | (m1_awvalid & m1_wvalid);

  assign in_rd_addr = (state_q == ST_RD_ADDR);
  assign in_rd_data = (state_q == ST_RD_DATA);
  assign in_wr_addr = (state_q == ST_WR_ADDR);
  assign in_wr_resp = (state_q == ST_WR_RESP);

  assign g_arvalid = grant_q ? m1_arvalid : m0_arvalid;
  assign g_rready  = grant_q ? m1_rready  : m0_rready;
  assign g_awvalid = grant_q ? m1_awvalid : m0_awvalid;
  assign g_wvalid  = grant_q ? m1_wvalid  : m0_wvalid;
  assign g_bready  = grant_q ? m1_bready  : m0_bready;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    sel          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          sel     = (req0 & req1) ? ~last_grant_q : req1;
          grant_d = sel;
          state_d = (sel ? rd_req1 : rd_req0) ? ST_RD_ADDR : ST_WR_ADDR;
        end
      end
      ST_RD_ADDR: if (s_arvalid & s_arready) state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (s_rvalid & s_rready) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      ST_WR_ADDR: begin
        // AW and W may complete in either order or together
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WR_RESP;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      ST_WR_RESP: begin
        if (s_bvalid & s_bready) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  assign s_arvalid = in_rd_addr & g_arvalid;
  assign s_araddr  = grant_q ? m1_araddr : m0_araddr;
  assign s_arprot  = grant_q ? m1_arprot : m0_arprot;
  assign s_rready  = in_rd_data & g_rready;

  assign s_awvalid = in_wr_addr & g_awvalid & ~aw_done_q;
  assign s_awaddr  = grant_q ? m1_awaddr : m0_awaddr;
  assign s_awprot  = grant_q ? m1_awprot : m0_awprot;
  assign s_wvalid  = in_wr_addr & g_wvalid & ~w_done_q;
  assign s_wdata   = grant_q ? m1_wdata : m0_wdata;
  assign s_wstrb   = grant_q ? m1_wstrb : m0_wstrb;
  assign s_bready  = in_wr_resp & g_bready;

  // Payloads fan out to both masters; only the granted master's valids/readies open
  assign m0_arready = in_rd_addr & ~grant_q & s_arready;
  assign m1_arready = in_rd_addr &  grant_q & s_arready;
  assign m0_rvalid  = in_rd_data & ~grant_q & s_rvalid;
  assign m1_rvalid  = in_rd_data &  grant_q & s_rvalid;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_rresp   = s_rresp;
  assign m1_rresp   = s_rresp;
  assign m0_awready = in_wr_addr & ~grant_q & ~aw_done_q & s_awready;
  assign m1_awready = in_wr_addr &  grant_q & ~aw_done_q & s_awready;
  assign m0_wready  = in_wr_addr & ~grant_q & ~w_done_q & s_wready;
  assign m1_wready  = in_wr_addr &  grant_q & ~w_done_q & s_wready;
  assign m0_bvalid  = in_wr_resp & ~grant_q & s_bvalid;
  assign m1_bvalid  = in_wr_resp &  grant_q & s_bvalid;
  assign m0_bresp   = s_bresp;
  assign m1_bresp   = s_bresp;

  assign debug_grant = grant_q;
  assign debug_state = state_q;

endmodule
